// File: rtl/shield_bitmap_erase.sv
// Shield bitmaps for N shields, with a multi-cycle diamond erase engine and a one-entry hit buffer.
// playGame low or reset high restores every shield to its initial shape.
module shield_bitmap_erase #(
  parameter int         NUM_SHIELDS = 4,
  parameter int         SHIELD_W    = 32,
  parameter int         SHIELD_H    = 16,
  parameter int         SCALE_LOG2  = 1,
  parameter int         PITCH_LOG2  = 7,
  parameter int         BLAST_R     = 2,
  parameter int         ARCH_H      = 4,
  parameter int         CHAMFER     = 4,
  parameter logic [7:0] COLOR       = 8'h5C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  input  logic        collision,
  input  logic        playGame,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        busy,
  output logic        hit_accepted,
  output logic        hit_dropped
);
  localparam int SW = (NUM_SHIELDS > 1) ? $clog2(NUM_SHIELDS) : 1;
  localparam int RW = $clog2(SHIELD_H);
  localparam int CW = $clog2(SHIELD_W);
  localparam logic signed [3:0] R_POS = 4'(BLAST_R);
  localparam logic signed [3:0] R_NEG = -R_POS;

  typedef enum logic {IDLE, ERASE} state_t;

  function automatic logic [SHIELD_W-1:0] init_row(input int r);
    logic [SHIELD_W-1:0] v;
    v = '0;
    for (int c = 0; c < SHIELD_W; c++) begin
      v[c] = (r >= 1) && (r <= SHIELD_H - 2) && (c >= 1) && (c <= SHIELD_W - 2) &&
             (r + c >= CHAMFER) && (r + (SHIELD_W - 1 - c) >= CHAMFER) &&
             !((r >= SHIELD_H - 1 - ARCH_H) && (c >= SHIELD_W / 4) && (c <= 3 * SHIELD_W / 4 - 1));
    end
    return v;
  endfunction

  logic [SHIELD_W-1:0] cell_q [NUM_SHIELDS][SHIELD_H];

  state_t          state_q, state_d;
  logic [SW-1:0]   csh_q, csh_d, psh_q, psh_d;
  logic [RW-1:0]   crow_q, crow_d, prow_q, prow_d;
  logic [CW-1:0]   ccol_q, ccol_d, pcol_q, pcol_d;
  logic            pend_q, pend_d;
  logic signed [3:0] dr_q, dr_d, dc_q, dc_d;
  logic            acc_q, acc_d, drop_q, drop_d;

  logic        restore, valid, hit, last, erase_en;
  logic [31:0] sh_w, col_w, row_w;
  int          tr, tc, adr, adc;

  assign restore = reset | ~playGame;

  always_comb begin
    sh_w  = 32'(offsetX) >> PITCH_LOG2;
    col_w = 32'(offsetX[PITCH_LOG2-1:0]) >> SCALE_LOG2;
    row_w = 32'(offsetY) >> SCALE_LOG2;
    valid = InsideRectangle && playGame && (sh_w < NUM_SHIELDS) &&
            (col_w < SHIELD_W) && (row_w < SHIELD_H);
    drawingRequest = valid && cell_q[sh_w[SW-1:0]][row_w[RW-1:0]][col_w[CW-1:0]];
  end

  assign RGBout       = COLOR;
  assign hit          = collision & drawingRequest;
  assign busy         = (state_q == ERASE) & ~restore;
  assign hit_accepted = acc_q & ~restore;
  assign hit_dropped  = drop_q & ~restore;

  // Current scan target; positions outside the diamond or the bitmap write nothing.
  always_comb begin
    tr  = int'(crow_q) + int'(dr_q);
    tc  = int'(ccol_q) + int'(dc_q);
    adr = (dr_q < 0) ? -int'(dr_q) : int'(dr_q);
    adc = (dc_q < 0) ? -int'(dc_q) : int'(dc_q);
    erase_en = (state_q == ERASE) && (adr + adc <= BLAST_R) &&
               (tr >= 0) && (tr < SHIELD_H) && (tc >= 0) && (tc < SHIELD_W);
    last = (dr_q == R_POS) && (dc_q == R_POS);
  end

  always_comb begin
    state_d = state_q;
    csh_d = csh_q;  crow_d = crow_q;  ccol_d = ccol_q;
    psh_d = psh_q;  prow_d = prow_q;  pcol_d = pcol_q;
    pend_d = pend_q;
    dr_d = dr_q;
    dc_d = dc_q;
    acc_d = 1'b0;
    drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = ERASE;
          csh_d = sh_w[SW-1:0];  crow_d = row_w[RW-1:0];  ccol_d = col_w[CW-1:0];
          dr_d = R_NEG;
          dc_d = R_NEG;
          acc_d = 1'b1;
        end
      end
      ERASE: begin
        if (!last) begin
          if (dc_q == R_POS) begin
            dc_d = R_NEG;
            dr_d = dr_q + 4'sd1;
          end else begin
            dc_d = dc_q + 4'sd1;
          end
          if (hit && !pend_q) begin
            pend_d = 1'b1;
            psh_d = sh_w[SW-1:0];  prow_d = row_w[RW-1:0];  pcol_d = col_w[CW-1:0];
            acc_d = 1'b1;
          end else if (hit) begin
            drop_d = 1'b1;
          end
        end else if (pend_q) begin
          // Pending entry becomes the next centre; a simultaneous hit refills the freed slot.
          csh_d = psh_q;  crow_d = prow_q;  ccol_d = pcol_q;
          dr_d = R_NEG;
          dc_d = R_NEG;
          pend_d = 1'b0;
          if (hit) begin
            pend_d = 1'b1;
            psh_d = sh_w[SW-1:0];  prow_d = row_w[RW-1:0];  pcol_d = col_w[CW-1:0];
            acc_d = 1'b1;
          end
        end else if (hit) begin
          csh_d = sh_w[SW-1:0];  crow_d = row_w[RW-1:0];  ccol_d = col_w[CW-1:0];
          dr_d = R_NEG;
          dc_d = R_NEG;
          acc_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restore) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      acc_q   <= 1'b0;
      drop_q  <= 1'b0;
      dr_q    <= R_NEG;
      dc_q    <= R_NEG;
      csh_q   <= '0;  crow_q <= '0;  ccol_q <= '0;
      psh_q   <= '0;  prow_q <= '0;  pcol_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      drop_q  <= drop_d;
      dr_q    <= dr_d;
      dc_q    <= dc_d;
      csh_q   <= csh_d;  crow_q <= crow_d;  ccol_q <= ccol_d;
      psh_q   <= psh_d;  prow_q <= prow_d;  pcol_q <= pcol_d;
    end
  end

  always_ff @(posedge clk) begin
    if (restore) begin
      for (int s = 0; s < NUM_SHIELDS; s++) begin
        for (int r = 0; r < SHIELD_H; r++) begin
          cell_q[s][r] <= init_row(r);
        end
      end
    end else if (erase_en) begin
      cell_q[csh_q][tr[RW-1:0]][tc[CW-1:0]] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shield_bitmap_erase.sv
// Scoreboard bench: expected hit pulses are queued at drive time and popped when the DUT pulses;
// the bitmap is compared against an independent cell model by full sweeps.
module tb_shield_bitmap_erase;
  logic        clk = 1'b0;
  logic        reset, InsideRectangle, collision, playGame;
  logic [10:0] offsetX, offsetY;
  logic        drawingRequest, busy, hit_accepted, hit_dropped;
  logic [7:0]  RGBout;

  always #5 clk = ~clk;

  shield_bitmap_erase dut (
    .clk(clk), .reset(reset), .offsetX(offsetX), .offsetY(offsetY),
    .InsideRectangle(InsideRectangle), .collision(collision), .playGame(playGame),
    .drawingRequest(drawingRequest), .RGBout(RGBout), .busy(busy),
    .hit_accepted(hit_accepted), .hit_dropped(hit_dropped)
  );

  int checks = 0;
  int failures = 0;
  bit model [4][16][32];
  int exp_q[$];
  int run = 0;
  int last_run = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit init_cell(input int r, input int c);
    return (r >= 1) && (r <= 14) && (c >= 1) && (c <= 30) && (r + c >= 4) &&
           (r + 31 - c >= 4) && !((r >= 11) && (c >= 8) && (c <= 23));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 32; c++)
          model[s][r][c] = init_cell(r, c);
  endtask

  task automatic model_blast(input int s, input int r, input int c);
    for (int dr = -2; dr <= 2; dr++)
      for (int dc = -2; dc <= 2; dc++)
        if ((dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc) <= 2 &&
            r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 32)
          model[s][r+dr][c+dc] = 1'b0;
  endtask

  // 1 = accepted pulse, 2 = dropped pulse
  always @(negedge clk) begin
    if (hit_accepted || hit_dropped) begin
      if (exp_q.size() == 0) check("pulse_unexpected", {hit_dropped, hit_accepted}, 0);
      else check("pulse", int'({hit_dropped, hit_accepted}), exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (busy) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic hit_raw(input int x, input int y, input int e);
    @(posedge clk); #1;
    offsetX = 11'(x);
    offsetY = 11'(y);
    InsideRectangle = 1'b1;
    collision = 1'b1;
    if (e != 0) exp_q.push_back(e);
    @(posedge clk); #1;
    collision = 1'b0;
  endtask

  task automatic hit_px(input int s, input int r, input int c, input int e);
    hit_raw(s * 128 + c * 2, r * 2, e);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (!busy && run == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic cell_chk(input string tag, input int s, input int r, input int c, input int e);
    @(posedge clk); #1;
    offsetX = 11'(s * 128 + c * 2);
    offsetY = 11'(r * 2);
    InsideRectangle = 1'b1;
    @(negedge clk);
    check(tag, drawingRequest, e);
  endtask

  task automatic sweep(input string tag);
    int errs;
    errs = 0;
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 32; c++) begin
          @(posedge clk); #1;
          offsetX = 11'(s * 128 + c * 2 + (c % 2) * 1);
          offsetY = 11'(r * 2 + (r % 2));
          InsideRectangle = 1'b1;
          @(negedge clk);
          if (drawingRequest !== model[s][r][c]) errs++;
        end
    check(tag, errs, 0);
  endtask

  task automatic restore_mid(input bit use_reset, input string tag);
    int bad;
    hit_px(0, 5, 16, 1);
    model_blast(0, 5, 16);
    @(posedge clk);
    hit_px(3, 5, 16, 1);
    repeat (5) @(posedge clk);
    #1;
    if (use_reset) reset = 1'b1;
    else playGame = 1'b0;
    @(negedge clk);
    check({tag, "_busy_during"}, busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    playGame = 1'b1;
    model_reset();
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) bad++;
    end
    check({tag, "_pending_gone"}, bad, 0);
    sweep({tag, "_sweep"});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    playGame = 1'b0;
    InsideRectangle = 1'b0;
    collision = 1'b0;
    offsetX = '0;
    offsetY = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_acc", hit_accepted, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    playGame = 1'b1;
    check("rgb", RGBout, 8'h5C);
    sweep("init_sweep");
    cell_chk("cell_0_7", 1, 0, 7, 0);
    cell_chk("cell_5_16", 0, 5, 16, 1);
    cell_chk("cell_14_10", 2, 14, 10, 0);
    cell_chk("cell_13_2", 3, 13, 2, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);

    // single centred hit
    hit_px(1, 6, 10, 1);
    model_blast(1, 6, 10);
    @(negedge clk);
    check("acc_t1", hit_accepted, 1);
    check("busy_t1", busy, 1);
    wait_idle();
    check("single_busy_len", last_run, 25);
    cell_chk("single_centre", 1, 6, 10, 0);
    cell_chk("single_edge", 1, 6, 12, 0);
    cell_chk("single_outside", 1, 6, 13, 1);
    sweep("single_sweep");

    // blasts clipped at the bitmap edges
    hit_px(0, 2, 2, 1);
    model_blast(0, 2, 2);
    wait_idle();
    check("edge_busy_len", last_run, 25);
    hit_px(3, 5, 30, 1);
    model_blast(3, 5, 30);
    wait_idle();
    hit_px(0, 13, 29, 1);
    model_blast(0, 13, 29);
    wait_idle();
    sweep("edge_sweep");

    // A at t, B at t+3 (pended), C at t+5 (dropped)
    hit_px(2, 8, 5, 1);
    model_blast(2, 8, 5);
    @(posedge clk);
    hit_px(2, 8, 20, 1);
    model_blast(2, 8, 20);
    hit_px(1, 10, 25, 2);
    wait_idle();
    check("buffer_busy_len", last_run, 50);
    sweep("buffer_sweep");

    // hits that must be ignored
    hit_raw(80, 12, 0);
    @(negedge clk);
    check("ign_gap_busy", busy, 0);
    hit_px(1, 6, 10, 0);
    @(negedge clk);
    check("ign_cleared_busy", busy, 0);
    hit_raw(4 * 128 + 20, 12, 0);
    @(negedge clk);
    check("ign_range_busy", busy, 0);

    restore_mid(1'b0, "restore_play");
    restore_mid(1'b1, "restore_reset");

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
